// File: rtl/tile_judge_if.sv
// Tile judge bus: groups the game-control inputs and the score/status outputs of tile_judge.
//   master: drives start, tick, row, key; observes score, lives, hit, miss, playing, game_over
//   slave : the judge itself
interface tile_judge_if #(
    parameter int unsigned SCORE_W = 8
);
    logic               start;      // one-cycle pulse: begin or restart a game
    logic               tick;       // one-cycle strobe: row is valid, new row at the hit line
    logic [3:0]         row;        // bit i = column i has a tile
    logic [3:0]         key;        // raw player buttons, active-high, asynchronous
    logic [SCORE_W-1:0] score;      // tiles hit this game
    logic [3:0]         lives;      // remaining lives
    logic               hit;        // pulse: cycle with at least one correct press
    logic               miss;       // pulse: cycle with at least one miss event
    logic               playing;    // high in PLAY
    logic               game_over;  // high in OVER

    modport master (
        output start, tick, row, key,
        input  score, lives, hit, miss, playing, game_over
    );

    modport slave (
        input  start, tick, row, key,
        output score, lives, hit, miss, playing, game_over
    );
endinterface

// File: rtl/tile_judge.sv
// Tile judge: scores player key presses against the 4-column tile row on the hit line.
// Sits downstream of the tile shift register (tick strobe + row) and feeds the score display
// and game-over logic.
//
// Ports:
//   CLOCK_50  in  system clock, all logic on posedge
//   reset     in  asynchronous active-high reset
//   bus       tile_judge_if.slave
//               start/tick/row/key in; score/lives/hit/miss/playing/game_over out
//
// Parameters:
//   LIVES    lives loaded when a game starts (1..15)
//   SCORE_W  score width; the score saturates at all-ones
//   STRICT   1: pressing an empty column costs a life; 0: such presses are ignored
module tile_judge #(
    parameter int unsigned LIVES   = 3,
    parameter int unsigned SCORE_W = 8,
    parameter bit          STRICT  = 1'b1
) (
    input logic         CLOCK_50,
    input logic         reset,
    tile_judge_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

    localparam logic [3:0] LivesInit = 4'(LIVES);

    state_e             state_q;

    // Key synchroniser chain plus a registered rising-edge detect.
    logic [3:0]         k0_q, k1_q, k2_q;
    logic [3:0]         press_q;

    // Current window: which columns carry a tile, and which were already hit.
    logic [3:0]         pending_q;
    logic [3:0]         done_q;

    logic [SCORE_W-1:0] score_q;
    logic [3:0]         lives_q;
    logic               hit_q, miss_q, playing_q, game_over_q;

    // Judgement of this cycle's presses against the window.
    logic [3:0]         correct;
    logic [3:0]         wrong;
    logic [3:0]         done_after;
    logic [3:0]         expired;
    logic [2:0]         n_correct;
    logic               miss_ev;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_d;
    logic [3:0]         lives_d;

    always_comb begin
        correct    = press_q & pending_q & ~done_q;
        wrong      = press_q & ~pending_q;
        // Presses are judged against the old window first; only then does a tick close it.
        done_after = done_q | correct;
        expired    = bus.tick ? (pending_q & ~done_after) : 4'b0000;
        miss_ev    = (|expired) | (STRICT & (|wrong));

        n_correct  = 3'(correct[0]) + 3'(correct[1]) + 3'(correct[2]) + 3'(correct[3]);
        score_sum  = {1'b0, score_q} + (SCORE_W + 1)'(n_correct);
        score_d    = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

        // At most one life per cycle, regardless of how many miss events coincide.
        lives_d    = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            k0_q        <= 4'b0000;
            k1_q        <= 4'b0000;
            k2_q        <= 4'b0000;
            press_q     <= 4'b0000;
            pending_q   <= 4'b0000;
            done_q      <= 4'b0000;
            score_q     <= '0;
            lives_q     <= LivesInit;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            k0_q    <= bus.key;
            k1_q    <= k0_q;
            k2_q    <= k1_q;
            // Registering the edge detect gives a key-to-pulse latency of three edges.
            press_q <= k1_q & ~k2_q;

            hit_q   <= 1'b0;
            miss_q  <= 1'b0;

            if (bus.start) begin
                // start wins over tick and presses in the same cycle; those are dropped.
                state_q     <= StPlay;
                playing_q   <= 1'b1;
                game_over_q <= 1'b0;
                score_q     <= '0;
                lives_q     <= LivesInit;
                pending_q   <= 4'b0000;
                done_q      <= 4'b0000;
            end else begin
                unique case (state_q)
                    StPlay: begin
                        hit_q   <= |correct;
                        miss_q  <= miss_ev;
                        score_q <= score_d;

                        if (bus.tick) begin
                            pending_q <= bus.row;
                            done_q    <= 4'b0000;
                        end else begin
                            done_q    <= done_after;
                        end

                        if (miss_ev) begin
                            lives_q <= lives_d;
                            if (lives_d == 4'd0) begin
                                state_q     <= StOver;
                                playing_q   <= 1'b0;
                                game_over_q <= 1'b1;
                            end
                        end
                    end
                    StIdle, StOver: begin
                        // Waiting for start; ticks and presses are ignored.
                    end
                    default: begin
                        state_q     <= StIdle;
                        playing_q   <= 1'b0;
                        game_over_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.hit       = hit_q;
    assign bus.miss      = miss_q;
    assign bus.playing   = playing_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_tile_judge.sv
// Self-checking bench for tile_judge. Two instances: A (LIVES=3, STRICT=1) and
// B (LIVES=1, STRICT=0). Expected output events are queued when stimulus is driven and
// popped when the DUT pulses hit/miss (or when the wait budget expires, latency -1).
module tb_tile_judge;

    typedef struct {
        int         lat;
        bit         hit;
        bit         miss;
        logic [7:0] score;
        logic [3:0] lives;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tile_judge_if #(.SCORE_W(8)) bus_a ();
    tile_judge_if #(.SCORE_W(8)) bus_b ();

    tile_judge #(.LIVES(3), .SCORE_W(8), .STRICT(1'b1)) dut_a (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus_a)
    );

    tile_judge #(.LIVES(1), .SCORE_W(8), .STRICT(1'b0)) dut_b (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus_b)
    );

    exp_t       sb_q[$];
    exp_t       e;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         lat;
    logic       h, m;
    logic [7:0] sc;
    logic [3:0] lv;
    int         m_score_a;

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_a.tick = 1'b0; bus_a.start = 1'b0;
            bus_b.tick = 1'b0; bus_b.start = 1'b0;
        end
    endtask

    // Wait up to max negedges for a hit/miss pulse on the selected DUT; lat = -1 on timeout.
    task automatic wait_out(input bit sel_b, input int max, input bit clr_key, output int o_lat,
                            output logic o_h, output logic o_m, output logic [7:0] o_sc,
                            output logic [3:0] o_lv);
        o_lat = -1; o_h = 1'b0; o_m = 1'b0;
        for (int i = 1; i <= max; i++) begin
            idle(1);
            if (clr_key) begin
                if (sel_b) bus_b.key = 4'b0000;
                else       bus_a.key = 4'b0000;
            end
            if (sel_b ? (bus_b.hit | bus_b.miss) : (bus_a.hit | bus_a.miss)) begin
                o_lat = i;
                o_h   = sel_b ? bus_b.hit  : bus_a.hit;
                o_m   = sel_b ? bus_b.miss : bus_a.miss;
                break;
            end
        end
        o_sc = sel_b ? bus_b.score : bus_a.score;
        o_lv = sel_b ? bus_b.lives : bus_a.lives;
    endtask

    task automatic push(input int l, input bit ht, input bit ms, input int s, input int lvs);
        exp_t x;
        x.lat = l; x.hit = ht; x.miss = ms; x.score = 8'(s); x.lives = 4'(lvs);
        sb_q.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        n_tests++;
        if ({bus_a.score, bus_a.lives, bus_a.hit, bus_a.miss, bus_a.playing, bus_a.game_over}
            !== {8'd0, 4'd3, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_a: got score=%0d lives=%0d hit=%b miss=%b play=%b over=%b want 0 3 0 0 0 0",
                     bus_a.score, bus_a.lives, bus_a.hit, bus_a.miss, bus_a.playing,
                     bus_a.game_over);
        end
        n_tests++;
        if ({bus_b.score, bus_b.lives, bus_b.playing} !== {8'd0, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: got score=%0d lives=%0d play=%b want 0 1 0",
                     bus_b.score, bus_b.lives, bus_b.playing);
        end
        // Ticks and presses in IDLE are ignored.
        bus_a.row = 4'b1111; bus_a.tick = 1'b1; bus_a.key = 4'b1111;
        push(-1, 0, 0, 0, 3);
        wait_out(0, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL idle_ignore: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
    endtask

    task automatic test_hit();
        bus_a.start = 1'b1;
        idle(1);
        n_tests++;
        if ({bus_a.playing, bus_a.game_over, bus_a.score, bus_a.lives} !== {2'b10, 8'd0, 4'd3}) begin
            n_fail++;
            $display("FAIL start_a: got play=%b over=%b score=%0d lives=%0d want 1 0 0 3",
                     bus_a.playing, bus_a.game_over, bus_a.score, bus_a.lives);
        end
        bus_a.row = 4'b0100; bus_a.tick = 1'b1;
        idle(1);
        bus_a.key = 4'b0100;
        m_score_a = 1;
        push(4, 1, 0, m_score_a, 3);
        wait_out(0, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if (lat !== e.lat) begin
            n_fail++;
            $display("FAIL hit_latency: got %0d want %0d", lat, e.lat);
        end
        n_tests++;
        if ({h, m, sc, lv} !== {e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL hit_result: got hit=%b miss=%b score=%0d lives=%0d want hit=%b miss=%b score=%0d lives=%0d",
                     h, m, sc, lv, e.hit, e.miss, e.score, e.lives);
        end
    endtask

    task automatic test_miss();
        bus_a.row = 4'b0001; bus_a.tick = 1'b1;
        idle(1);
        idle(3);
        bus_a.row = 4'b0000; bus_a.tick = 1'b1;
        push(1, 0, 1, m_score_a, 2);
        wait_out(0, 8, 0, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL expire_miss: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
    endtask

    task automatic test_hold();
        int pulses;
        bus_a.row = 4'b0010; bus_a.tick = 1'b1;
        idle(1);
        bus_a.key = 4'b0010;
        m_score_a = m_score_a + 1;
        push(4, 1, 0, m_score_a, 2);
        wait_out(0, 8, 0, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL hold_first: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1);
            if (bus_a.hit | bus_a.miss) pulses++;
        end
        n_tests++;
        if (pulses !== 0 || bus_a.score !== 8'(m_score_a)) begin
            n_fail++;
            $display("FAIL hold_single: got extra_pulses=%0d score=%0d want 0 %0d",
                     pulses, bus_a.score, m_score_a);
        end
        bus_a.key = 4'b0000;
        idle(2);
        // Second press on an already-hit column in the same window.
        bus_a.key = 4'b0010;
        push(-1, 0, 0, m_score_a, 2);
        wait_out(0, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL double_press: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
    endtask

    task automatic test_strict();
        // STRICT=1: wrong column costs a life.
        bus_a.row = 4'b0001; bus_a.tick = 1'b1;
        idle(1);
        bus_a.key = 4'b1000;
        push(4, 0, 1, m_score_a, 1);
        wait_out(0, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL strict_wrong: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
        idle(2);
        bus_a.key = 4'b0001;
        m_score_a = m_score_a + 1;
        push(4, 1, 0, m_score_a, 1);
        wait_out(0, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL strict_resolve: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
        // STRICT=0: the same wrong press is ignored.
        bus_b.start = 1'b1;
        idle(1);
        bus_b.row = 4'b0001; bus_b.tick = 1'b1;
        idle(1);
        bus_b.key = 4'b1000;
        push(-1, 0, 0, 0, 1);
        wait_out(1, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL lenient_wrong: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
        bus_b.key = 4'b0001;
        push(4, 1, 0, 1, 1);
        wait_out(1, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL lenient_hit: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
    endtask

    task automatic test_all_four();
        bus_a.row = 4'b1111; bus_a.tick = 1'b1;
        idle(1);
        bus_a.key = 4'b1111;
        m_score_a = sat8(m_score_a + 4);
        push(4, 1, 0, m_score_a, 1);
        wait_out(0, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL four_keys: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
        // Run the score up to 251 with full rows.
        for (int w = 0; w < 61; w++) begin
            idle(2);
            bus_a.row = 4'b1111; bus_a.tick = 1'b1;
            idle(1);
            bus_a.key = 4'b1111;
            idle(1);
            bus_a.key = 4'b0000;
            idle(4);
            m_score_a = sat8(m_score_a + 4);
        end
        bus_a.row = 4'b0111; bus_a.tick = 1'b1;
        idle(1);
        bus_a.key = 4'b0111;
        m_score_a = sat8(m_score_a + 3);
        push(4, 1, 0, m_score_a, 1);
        wait_out(0, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL score_254: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
        idle(2);
        bus_a.row = 4'b1111; bus_a.tick = 1'b1;
        idle(1);
        bus_a.key = 4'b1111;
        m_score_a = sat8(m_score_a + 4);
        push(4, 1, 0, m_score_a, 1);
        wait_out(0, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL score_saturate: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
    endtask

    task automatic test_same_cycle();
        // Press lands on the same edge as a tick that loads an empty row: judged on the old window.
        bus_b.row = 4'b0001; bus_b.tick = 1'b1;
        idle(1);
        bus_b.key = 4'b0001;
        idle(1);
        bus_b.key = 4'b0000;
        idle(2);
        bus_b.row = 4'b0000; bus_b.tick = 1'b1;
        push(1, 1, 0, 2, 1);
        wait_out(1, 8, 0, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL tick_press_same: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
    endtask

    task automatic test_game_over();
        idle(2);
        bus_b.row = 4'b0100; bus_b.tick = 1'b1;
        idle(3);
        bus_b.row = 4'b0000; bus_b.tick = 1'b1;
        push(1, 0, 1, 2, 0);
        wait_out(1, 8, 0, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL last_life: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
        n_tests++;
        if ({bus_b.playing, bus_b.game_over} !== 2'b01) begin
            n_fail++;
            $display("FAIL over_flags: got play=%b over=%b want 0 1", bus_b.playing, bus_b.game_over);
        end
        bus_b.row = 4'b1111; bus_b.tick = 1'b1; bus_b.key = 4'b1111;
        push(-1, 0, 0, 2, 0);
        wait_out(1, 8, 1, lat, h, m, sc, lv);
        e = sb_q.pop_front();
        n_tests++;
        if ({lat, h, m, sc, lv} !== {e.lat, e.hit, e.miss, e.score, e.lives}) begin
            n_fail++;
            $display("FAIL over_ignore: got lat=%0d hit=%b miss=%b score=%0d lives=%0d want lat=%0d hit=%b miss=%b score=%0d lives=%0d",
                     lat, h, m, sc, lv, e.lat, e.hit, e.miss, e.score, e.lives);
        end
        bus_b.start = 1'b1;
        idle(1);
        n_tests++;
        if ({bus_b.score, bus_b.lives, bus_b.playing, bus_b.game_over} !== {8'd0, 4'd1, 2'b10}) begin
            n_fail++;
            $display("FAIL restart: got score=%0d lives=%0d play=%b over=%b want 0 1 1 0",
                     bus_b.score, bus_b.lives, bus_b.playing, bus_b.game_over);
        end
    endtask

    task automatic test_midgame_reset();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus_a.score, bus_a.lives, bus_a.playing, bus_a.game_over} !== {8'd0, 4'd3, 2'b00}) begin
            n_fail++;
            $display("FAIL async_reset: got score=%0d lives=%0d play=%b over=%b want 0 3 0 0",
                     bus_a.score, bus_a.lives, bus_a.playing, bus_a.game_over);
        end
        idle(1);
        rst = 1'b0;
        idle(1);
        bus_a.start = 1'b1;
        idle(1);
        n_tests++;
        if ({bus_a.score, bus_a.lives, bus_a.playing} !== {8'd0, 4'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL fresh_game: got score=%0d lives=%0d play=%b want 0 3 1",
                     bus_a.score, bus_a.lives, bus_a.playing);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.tick = 1'b0; bus_a.row = 4'b0000; bus_a.key = 4'b0000;
        bus_b.start = 1'b0; bus_b.tick = 1'b0; bus_b.row = 4'b0000; bus_b.key = 4'b0000;
        m_score_a = 0;
        test_reset();
        test_hit();
        test_miss();
        test_hold();
        test_strict();
        test_all_four();
        test_same_cycle();
        test_game_over();
        test_midgame_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
